switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer.sv | 96 +++++++++
 tb/tb_switch_debouncer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Synchronises and debounces raw slide-switch pins. Each bit is handled
//   independently. A bit's clean level changes only after its synchronised
//   input has differed from the clean level for DEBOUNCE_CYCLES consecutive
//   cycles. Every change produces a one-cycle rise or fall strobe, and
//   'changed' strobes once on any edge where at least one bit changed.
//
// Ports
//   clk       system clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   sw_raw    raw switch pins, asynchronous to clk
//   sw_clean  debounced switch levels
//   sw_rise   one-cycle pulse per bit on accepted 0->1
//   sw_fall   one-cycle pulse per bit on accepted 1->0
//   changed   one-cycle pulse when any bit of sw_clean changes
module switch_debouncer #(
    parameter int unsigned WIDTH           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] clean_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             changed_q;
    logic             changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // State register: synchroniser, per-bit counters, clean levels and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    // Per-bit next state: a bit is STABLE while sync2 matches clean (counter
    // held at zero) and COUNTING otherwise; any bounce back restarts the count.
    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]   = '0;
                clean_d[i] = sync2_q[i];
                rise_d[i]  = sync2_q[i];
                fall_d[i]  = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    assign sw_clean = clean_q;
    assign sw_rise  = rise_q;
    assign sw_fall  = fall_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
//   Drives two debouncer instances (DEBOUNCE_CYCLES = 4 and 1) from the same
//   switch inputs. A reference model predicts outputs per edge and queues
//   them; a monitor pops and compares on every falling edge. Directed
//   latency checks cover the documented scenarios, then random stimulus runs.
module tb_switch_debouncer;

    localparam int unsigned W    = 5;
    localparam int          NDUT = 2;

    typedef struct packed {
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         changed;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] clean4, rise4, fall4;
    logic [W-1:0] clean1, rise1, fall1;
    logic         changed4, changed1;

    int errors = 0;
    int checks = 0;

    obs_t         exp_q  [NDUT][$];
    logic [W-1:0] m_samp [NDUT][$];
    logic [W-1:0] m_clean[NDUT];
    int           m_d    [NDUT];

    switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_raw  (sw_raw),
        .sw_clean(clean4),
        .sw_rise (rise4),
        .sw_fall (fall4),
        .changed (changed4)
    );

    switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_raw  (sw_raw),
        .sw_clean(clean1),
        .sw_rise (rise1),
        .sw_fall (fall1),
        .changed (changed1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    // Reference model. m_samp holds every raw sample since reset, prefixed by
    // two zeros for the reset synchroniser, so the synchronised level seen at
    // edge n is m_samp[n-1]. A bit is accepted when the last D synchronised
    // levels all differ from its clean level.
    task automatic model_step(input int d);
        obs_t         e;
        logic [W-1:0] prev;
        logic [W-1:0] s;
        int           vi;
        int           lo;
        bit           all_diff;
        if (!rst_n) begin
            m_samp[d].delete();
            m_samp[d].push_back('0);
            m_samp[d].push_back('0);
            m_clean[d] = '0;
            e = '0;
        end else begin
            prev = m_clean[d];
            vi   = m_samp[d].size() - 2;
            lo   = vi - (m_d[d] - 1);
            if (lo >= 0) begin
                for (int b = 0; b < int'(W); b++) begin
                    all_diff = 1'b1;
                    for (int j = lo; j <= vi; j++) begin
                        s = m_samp[d][j];
                        if (s[b] == prev[b]) all_diff = 1'b0;
                    end
                    if (all_diff) m_clean[d][b] = ~prev[b];
                end
            end
            m_samp[d].push_back(sw_raw);
            e.clean   = m_clean[d];
            e.rise    = m_clean[d] & ~prev;
            e.fall    = prev & ~m_clean[d];
            e.changed = |(e.rise | e.fall);
        end
        exp_q[d].push_back(e);
    endtask

    initial begin
        m_d[0] = 4;
        m_d[1] = 1;
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
        end
    end

    // Monitor: every falling edge, pop the prediction and compare.
    initial begin
        obs_t e;
        obs_t a;
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (exp_q[d].size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty D=%0d at %0t: got no prediction, required one", m_d[d], $time);
                end else begin
                    e = exp_q[d].pop_front();
                    if (!rst_n) e = '0;
                    a = (d == 0) ? {clean4, rise4, fall4, changed4} : {clean1, rise1, fall1, changed1};
                    if (a !== e) begin
                        errors++;
                        $display("FAIL outputs D=%0d at %0t: got clean=%b rise=%b fall=%b changed=%b, required clean=%b rise=%b fall=%b changed=%b",
                                 m_d[d], $time, a.clean, a.rise, a.fall, a.changed,
                                 e.clean, e.rise, e.fall, e.changed);
                    end
                end
            end
        end
    end

    // Apply a change (or release reset), then find the edge at which the
    // expected pulse vector appears on each instance.
    task automatic measure(input string name, input logic [W-1:0] new_raw,
                           input logic [W-1:0] mask, input bit is_rise,
                           input int exp4, input int exp1, input bit release_rst);
        int lat4 = -1;
        int lat1 = -1;
        int cnt4 = 0;
        @(posedge clk);
        #2;
        if (release_rst) rst_n = 1'b1;
        else             sw_raw = new_raw;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (changed4) cnt4++;
            if (lat4 < 0 && ((is_rise ? rise4 : fall4) == mask)) lat4 = k;
            if (lat1 < 0 && ((is_rise ? rise1 : fall1) == mask)) lat1 = k;
        end
        check({name, "_edge_d4"}, lat4, exp4);
        check({name, "_edge_d1"}, lat1, exp1);
        check({name, "_changed_pulses_d4"}, cnt4, 1);
    endtask

    initial begin
        int cnt;
        int lat_r;
        int lat_f;
        int clean_at3;

        rst_n  = 1'b0;
        sw_raw = 5'b11111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_clean_d4", int'(clean4), 0);
        check("reset_pulses_d4", int'({rise4, fall4, changed4}), 0);

        // Switches held high through reset are re-debounced after release.
        measure("reset_release", 5'b11111, 5'b11111, 1'b1, 6, 3, 1'b1);
        measure("all_fall", 5'b00000, 5'b11111, 1'b0, 6, 3, 1'b0);

        measure("press", 5'b00100, 5'b00100, 1'b1, 6, 3, 1'b0);
        measure("release", 5'b00000, 5'b00100, 1'b0, 6, 3, 1'b0);

        // Bounce: 1,0,1,0 held 2 cycles each, then settle at 1.
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            sw_raw[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (changed4) cnt++;
            @(negedge clk);
            if (changed4) cnt++;
        end
        check("bounce_pulses_d4", cnt, 0);
        measure("bounce_settle", 5'b00001, 5'b00001, 1'b1, 6, 3, 1'b0);
        measure("bounce_release", 5'b00000, 5'b00001, 1'b0, 6, 3, 1'b0);

        measure("simultaneous", 5'b10011, 5'b10011, 1'b1, 6, 3, 1'b0);
        measure("simultaneous_off", 5'b00000, 5'b10011, 1'b0, 6, 3, 1'b0);

        // Reset three edges into a count discards it.
        cnt = 0;
        @(posedge clk);
        #2;
        sw_raw = 5'b00010;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (changed4) cnt++;
        end
        #2;
        rst_n = 1'b0;
        check("mid_count_pulses_d4", cnt, 0);
        repeat (2) @(posedge clk);
        measure("mid_count_rerun", 5'b00010, 5'b00010, 1'b1, 6, 3, 1'b1);
        measure("mid_count_off", 5'b00000, 5'b00010, 1'b0, 6, 3, 1'b0);

        // One-cycle glitch: passes the D=1 filter as rise then fall.
        cnt       = 0;
        lat_r     = -1;
        lat_f     = -1;
        clean_at3 = -1;
        @(posedge clk);
        #2;
        sw_raw = 5'b10000;
        @(posedge clk);
        #2;
        sw_raw = 5'b00000;
        @(negedge clk);
        if (changed4) cnt++;
        for (int k = 2; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (changed4) cnt++;
            if (k == 3) clean_at3 = int'(clean1[4]);
            if (lat_r < 0 && rise1 == 5'b10000) lat_r = k;
            if (lat_f < 0 && fall1 == 5'b10000) lat_f = k;
        end
        check("glitch_rise_edge_d1", lat_r, 3);
        check("glitch_fall_edge_d1", lat_f, 4);
        check("glitch_clean_edge3_d1", clean_at3, 1);
        check("glitch_pulses_d4", cnt, 0);

        // Random phase: bit flips with varied hold times and occasional resets.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #2;
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0)
                sw_raw = sw_raw ^ W'($urandom_range(1, (1 << W) - 1));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
